// File: rtl/miscv_pkg.sv
// -----------------------------------------------------------------------------
// miscv_pkg
// Shared definitions for the RAM target: default address and data geometry,
// the word size in bits, the controller state encoding and a helper that
// sizes a word-index bus for a given storage depth.
// -----------------------------------------------------------------------------
package miscv_pkg;

    localparam int ADDR_WIDTH       = 10;
    localparam int DATA_WIDTH_BYTES = 4;
    localparam int WORD_SIZE        = 8 * DATA_WIDTH_BYTES;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of an index able to address 'depth' words (never zero).
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// -----------------------------------------------------------------------------
// ram_bank
// Single-port word storage organised as DEPTH words of LANES bytes. Writes
// update only lanes whose active-low enable is low; a request with every
// enable high is a read, whose data appears on rdata after the clock edge
// and is held there until the next read.
//
// Ports
//   clk        rising-edge clock
//   en         perform an access this cycle
//   wenable_n  per-lane write enables, active low (all ones = read)
//   addr       word index
//   wdata      write data, lane i in bits [8i+7:8i]
//   rdata      registered read data
// -----------------------------------------------------------------------------
module ram_bank
    import miscv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic               clk,
    input  logic               en,
    input  logic [LANES-1:0]   wenable_n,
    input  logic [IDX_W-1:0]   addr,
    input  logic [8*LANES-1:0] wdata,
    output logic [8*LANES-1:0] rdata
);

    logic [LANES-1:0][7:0] mem [DEPTH];

    // NOTE: storage and its read register are deliberately not reset; the
    // owner clears the array word by word, and a memory with a reset port
    // cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!wenable_n[i]) begin
                    mem[addr][i] <= wdata[8*i +: 8];
                end
            end
            if (&wenable_n) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_target.sv
// -----------------------------------------------------------------------------
// ram_target
// Valid/ready memory target. After reset the controller spends DEPTH_WORDS
// cycles zeroing storage (INIT), then serves one request per cycle (RUN).
// Each accepted request yields exactly one response, held until consumed.
// Misaligned or out-of-range addresses return rsp_err with zero data and
// leave storage untouched.
//
// Ports
//   clk           rising-edge clock
//   rstL          synchronous reset, active low
//   req_valid     request present
//   req_ready     request accepted this cycle
//   req_addr      byte address
//   req_wenableL  per-lane write enables, active low (all ones = read)
//   req_wdata     write data, lane i in bits [8i+7:8i]
//   rsp_valid     response held
//   rsp_ready     initiator consumes the response
//   rsp_rdata     read data (zero for writes and errors)
//   rsp_err       request was rejected
// -----------------------------------------------------------------------------
module ram_target
    import miscv_pkg::*;
#(
    parameter int ADDR_WIDTH       = miscv_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH_BYTES = miscv_pkg::DATA_WIDTH_BYTES,
    parameter int DEPTH_WORDS      = 256
) (
    input  logic                          clk,
    input  logic                          rstL,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH_BYTES-1:0]   req_wenableL,
    input  logic [8*DATA_WIDTH_BYTES-1:0] req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [8*DATA_WIDTH_BYTES-1:0] rsp_rdata,
    output logic                          rsp_err
);

    localparam int IDX_W = index_width(DEPTH_WORDS);
    localparam int DW    = 8 * DATA_WIDTH_BYTES;

    state_e                  state, state_next;
    logic [IDX_W-1:0]        init_count, init_count_next;

    logic [ADDR_WIDTH-3:0]   word_index;
    logic [31:0]             word_index_ext;
    logic                    req_error;
    logic                    accept;
    logic                    rsp_read;

    logic                    bank_en;
    logic [DATA_WIDTH_BYTES-1:0] bank_wenable_n;
    logic [IDX_W-1:0]        bank_addr;
    logic [DW-1:0]           bank_wdata;
    logic [DW-1:0]           bank_rdata;

    // Range check is done at 32 bits so it stays meaningful when the
    // address space exactly matches the storage depth.
    assign word_index     = req_addr[ADDR_WIDTH-1:2];
    assign word_index_ext = 32'(word_index);
    assign req_error      = (req_addr[1:0] != 2'b00) ||
                            (word_index_ext >= 32'(DEPTH_WORDS));
    assign accept         = req_valid && req_ready;

    // NOTE: every state element is updated with non-blocking assignments so
    // all flops sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstL) begin
            state      <= ST_INIT;
            init_count <= '0;
        end else begin
            state      <= state_next;
            init_count <= init_count_next;
        end
    end

    // NOTE: each output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        init_count_next = init_count;
        req_ready       = 1'b0;
        bank_en         = 1'b0;
        bank_wenable_n  = '1;
        bank_addr       = word_index[IDX_W-1:0];
        bank_wdata      = req_wdata;

        case (state)
            ST_INIT: begin
                bank_en        = rstL;
                bank_wenable_n = '0;
                bank_addr      = init_count;
                bank_wdata     = '0;
                if (init_count == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    init_count_next = init_count + 1'b1;
                end
            end
            ST_RUN: begin
                // Gating with rstL keeps a write presented during reset from
                // reaching storage.
                req_ready = rstL && (!rsp_valid || rsp_ready);
                bank_en   = req_valid && req_ready && !req_error;
                bank_wenable_n = req_wenableL;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Response register: a new acceptance overrides consumption, which is
    // what gives back-to-back responses with no bubble.
    always_ff @(posedge clk) begin
        if (!rstL) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_read  <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req_error;
            rsp_read  <= !req_error && (&req_wenableL);
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_read  <= 1'b0;
        end
    end

    // The bank read register only changes on a read acceptance, so it holds
    // stable while the response is back-pressured.
    assign rsp_rdata = rsp_read ? bank_rdata : '0;

    ram_bank #(
        .LANES (DATA_WIDTH_BYTES),
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk       (clk),
        .en        (bank_en),
        .wenable_n (bank_wenable_n),
        .addr      (bank_addr),
        .wdata     (bank_wdata),
        .rdata     (bank_rdata)
    );

endmodule

// File: tb/tb_ram_target.sv
// -----------------------------------------------------------------------------
// tb_ram_target
// Self-checking bench for ram_target. A byte-array model and a queue of
// expected responses predict every output; stimulus is randomized with
// $urandom. ADDR_WIDTH is 11 so that byte address 0x400 maps to word 256.
// -----------------------------------------------------------------------------
module tb_ram_target;

    localparam int AW    = 11;
    localparam int LANES = 4;
    localparam int DEPTH = 256;
    localparam int DW    = 8 * LANES;

    logic              clk = 1'b0;
    logic              rstL;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [LANES-1:0]  req_wenableL;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;

    always #5 clk = ~clk;

    ram_target #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH_BYTES (LANES),
        .DEPTH_WORDS      (DEPTH)
    ) dut (
        .clk          (clk),
        .rstL         (rstL),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wenableL (req_wenableL),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [LANES-1:0] wen;
        logic [DW-1:0]    wdata;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_mem [DEPTH*LANES];
    req_t       req_q [$];
    rsp_t       exp_q [$];
    logic [DW-1:0] last_rdata;
    logic          last_err;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < DEPTH*LANES; i++) model_mem[i] = 8'h00;
    endtask

    function automatic rsp_t model_apply(input req_t r);
        rsp_t s;
        int   idx;
        idx     = int'(r.addr) / 4;
        s.err   = (int'(r.addr) % 4 != 0) || (idx >= DEPTH);
        s.rdata = '0;
        if (!s.err) begin
            if (r.wen == '1) begin
                for (int i = 0; i < LANES; i++) s.rdata[8*i +: 8] = model_mem[idx*LANES + i];
            end else begin
                for (int i = 0; i < LANES; i++)
                    if (!r.wen[i]) model_mem[idx*LANES + i] = r.wdata[8*i +: 8];
            end
        end
        return s;
    endfunction

    function automatic req_t mk(input int addr, input logic [LANES-1:0] wen, input logic [DW-1:0] d);
        req_t r;
        r.addr  = AW'(addr);
        r.wen   = wen;
        r.wdata = d;
        return r;
    endfunction

    // ---------------- traffic engine ----------------
    // ready_mode: 0 = always ready, 1 = random, 2 = low for first 3 cycles.
    task automatic run_traffic(input int max_cycles, input int ready_mode, input int gap_pct);
        int   cyc = 0;
        logic exp_ready;
        logic holding = 1'b0;
        while ((req_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            req_valid = (req_q.size() > 0) && (holding || ($urandom_range(99) >= gap_pct));
            if (req_q.size() > 0) begin
                req_addr     = req_q[0].addr;
                req_wenableL = req_q[0].wen;
                req_wdata    = req_q[0].wdata;
            end
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(1));
                default: rsp_ready = (cyc >= 3);
            endcase
            #1;
            tests++;
            if (rsp_valid !== (exp_q.size() > 0)) begin
                fails++;
                $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                tests++;
                if (rsp_rdata !== exp_q[0].rdata || rsp_err !== exp_q[0].err) begin
                    fails++;
                    $display("FAIL rsp_data cyc=%0d: got %h/%b expected %h/%b",
                             cyc, rsp_rdata, rsp_err, exp_q[0].rdata, exp_q[0].err);
                end
            end
            exp_ready = (exp_q.size() == 0) || rsp_ready;
            tests++;
            if (req_ready !== exp_ready) begin
                fails++;
                $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
            end
            if (exp_q.size() > 0 && rsp_ready) begin
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                void'(exp_q.pop_front());
            end
            holding = req_valid && !exp_ready;
            if (req_valid && exp_ready) exp_q.push_back(model_apply(req_q.pop_front()));
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tests++;
        if (req_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL traffic_timeout: %0d requests and %0d responses outstanding, expected 0",
                     req_q.size(), exp_q.size());
            req_q.delete();
            exp_q.delete();
        end
    endtask

    // Release reset and count cycles until req_ready rises. A write is
    // presented throughout INIT to show it is ignored.
    task automatic wait_init();
        int low = 0;
        int bad_rsp = 0;
        logic seen = 1'b0;
        rstL         = 1'b1;
        req_valid    = 1'b1;
        req_addr     = AW'(12'h020);
        req_wenableL = '0;
        req_wdata    = '1;
        rsp_ready    = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            #1;
            if (req_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
            low++;
            if (rsp_valid !== 1'b0) bad_rsp++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        tests++;
        if (!seen || low != DEPTH) begin
            fails++;
            $display("FAIL init_cycles: got %0d ready-low cycles (ready seen %b) expected %0d", low, seen, DEPTH);
        end
        tests++;
        if (bad_rsp != 0) begin
            fails++;
            $display("FAIL init_rsp_valid: got %0d cycles with rsp_valid high expected 0", bad_rsp);
        end
        model_clear();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstL = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_addr = '0; req_wenableL = '1; req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: got ready=%b valid=%b expected 0/0", req_ready, rsp_valid);
        end
        tests++;
        if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_rdata, rsp_err);
        end
        wait_init();
        req_q.push_back(mk(12'h3FC, '1, '0));
        req_q.push_back(mk(12'h020, '1, '0));
        run_traffic(50, 0, 0);
        tests++;
        if (last_rdata !== 32'h0000_0000 || last_err !== 1'b0) begin
            fails++;
            $display("FAIL init_readback: got %h/%b expected 00000000/0", last_rdata, last_err);
        end
    endtask

    task automatic test_byte_lane();
        req_q.push_back(mk(12'h010, 4'b0000, 32'hDEAD_BEEF));
        req_q.push_back(mk(12'h010, 4'b1110, 32'h0000_00AA));
        req_q.push_back(mk(12'h010, 4'b1111, 32'h0));
        run_traffic(50, 0, 0);
        tests++;
        if (last_rdata !== 32'hDEAD_BEAA || last_err !== 1'b0) begin
            fails++;
            $display("FAIL byte_lane: got %h/%b expected deadbeaa/0", last_rdata, last_err);
        end
    endtask

    task automatic test_errors();
        req_q.push_back(mk(12'h012, 4'b1111, 32'h0));
        run_traffic(50, 0, 0);
        tests++;
        if (last_err !== 1'b1 || last_rdata !== '0) begin
            fails++;
            $display("FAIL misaligned_read: got %h/%b expected 00000000/1", last_rdata, last_err);
        end
        req_q.push_back(mk(12'h400, 4'b0000, 32'hCAFE_F00D));
        run_traffic(50, 0, 0);
        tests++;
        if (last_err !== 1'b1 || last_rdata !== '0) begin
            fails++;
            $display("FAIL range_write: got %h/%b expected 00000000/1", last_rdata, last_err);
        end
        // Word 0 must be untouched by the rejected write (index wraps to 0).
        req_q.push_back(mk(12'h000, 4'b1111, 32'h0));
        run_traffic(50, 0, 0);
        tests++;
        if (last_rdata !== 32'h0 || last_err !== 1'b0) begin
            fails++;
            $display("FAIL range_no_write: got %h/%b expected 00000000/0", last_rdata, last_err);
        end
        req_q.push_back(mk(12'h7FC, 4'b1111, 32'h0));
        req_q.push_back(mk(12'h013, 4'b0000, 32'h1111_1111));
        run_traffic(50, 0, 0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++)
            req_q.push_back(mk(4 * $urandom_range(DEPTH - 1), 4'($urandom_range(15)), DW'($urandom)));
        run_traffic(50, 2, 0);
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 20; k++) begin
            int a;
            a = 4 * $urandom_range(DEPTH - 1);
            req_q.push_back(mk(a, 4'b0000, DW'($urandom)));
            req_q.push_back(mk(a, 4'b1111, 32'h0));
        end
        run_traffic(100, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            int   a;
            logic [LANES-1:0] w;
            a = ($urandom_range(9) == 0) ? $urandom_range(2**AW - 1) : 4 * $urandom_range(15);
            w = ($urandom_range(1) == 0) ? 4'b1111 : 4'($urandom_range(15));
            req_q.push_back(mk(a, w, DW'($urandom)));
        end
        run_traffic(3000, 1, 30);
    endtask

    task automatic test_reset_mid();
        req_q.push_back(mk(12'h040, 4'b0000, 32'h1234_5678));
        run_traffic(50, 0, 0);
        // Leave a read response held, then reset with a write presented.
        req_valid = 1'b1; req_addr = AW'(12'h040); req_wenableL = '1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_held: got rsp_valid=%b expected 1", rsp_valid);
        end
        rstL = 1'b0;
        req_valid = 1'b1; req_addr = AW'(12'h080); req_wenableL = '0; req_wdata = '1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got valid=%b ready=%b data=%h err=%b expected 0/0/0/0",
                     rsp_valid, req_ready, rsp_rdata, rsp_err);
        end
        exp_q.delete();
        wait_init();
        req_q.push_back(mk(12'h080, 4'b1111, 32'h0));
        req_q.push_back(mk(12'h040, 4'b1111, 32'h0));
        run_traffic(50, 0, 0);
        tests++;
        if (last_rdata !== 32'h0 || last_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_readback: got %h/%b expected 00000000/0", last_rdata, last_err);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_errors();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
